traffic_scheduler: RTL and testbench
====================================

// Module: traffic_scheduler
// PURPOSE
// Central sequencer for all car lanes of the road screen. Owns one shared 25MHz prescaler
// and derives a per-lane step schedule from lane index and difficulty level. Holds every
// lane's car X position and steps it with wrap-around; start/pause/stop/level-up come from game FSM.
// Renderer and collision logic consume the packed positions and the one-cycle o_step pulses.
// PARAMETERS
// N_LANES      4        number of car lanes scheduled
// TICK_CYCLES  1250000  i_Clk cycles per base tick (50 ms at 25 MHz)
// X_MAX        20       last grid column; positions span 0..X_MAX
// BASE_PERIOD  10       lane-0 step period at level 0, in base ticks (0.5 s)
// MIN_PERIOD   2        floor on any lane period, in base ticks
// PORTS
// i_Clk        in   1          system clock, 25 MHz; everything on rising edge
// i_Reset      in   1          synchronous, active-high reset
// i_start      in   1          pulse: load positions/level and begin scheduling (IDLE only)
// i_stop       in   1          pulse: return to IDLE, positions held
// i_pause      in   1          level: while high in RUN/PAUSE, scheduling frozen
// i_level_up   in   1          pulse: level+1, saturating at 7
// i_level      in   3          level loaded on start
// i_init_x     in   N_LANES*5  start X per lane, lane k at [5k+4:5k]; values >X_MAX load as X_MAX
// o_car_x      out  N_LANES*5  current X per lane, same packing
// o_step       out  N_LANES    one-cycle pulse per lane, high in the cycle its o_car_x changes
// o_level      out  3          current level
// o_state      out  2          0 IDLE, 1 LOAD, 2 RUN, 3 PAUSE
// o_running    out  1          high in RUN only
// BEHAVIOUR
// - Reset: state IDLE; o_car_x, o_step, o_level, o_running, prescaler, lane counters all 0.
// - All outputs registered. Priority in one cycle: i_Reset > i_stop > i_pause > i_level_up.
// - IDLE: i_start -> LOAD. i_start ignored in any other state. o_car_x holds last value.
// - LOAD (exactly 1 cycle): o_car_x <= clamped i_init_x; o_level <= i_level; prescaler and
//   lane counters <= 0; -> RUN. i_stop during LOAD -> IDLE; i_pause high -> PAUSE.
// - RUN: prescaler counts 0..TICK_CYCLES-1; base_tick asserted when prescaler==TICK_CYCLES-1.
//   First base_tick is TICK_CYCLES cycles after entry to RUN from LOAD.
// - Lane period p(k,L) = max(BASE_PERIOD - k - 2*L, MIN_PERIOD), 4-bit unsigned; compute
//   signed/saturated, no underflow. On base_tick: if cnt[k] >= p-1 then cnt[k]<=0 and lane steps,
//   else cnt[k]++. Use >= so a level-up that shortens p fires on the next base_tick.
// - Step: even k increments (X_MAX -> 0), odd k decrements (0 -> X_MAX). Lanes step
//   simultaneously and independently; o_step[k]=1 for exactly that cycle.
// - i_level_up in RUN/PAUSE: o_level+1, stays 7 at 7; counters and prescaler untouched. Ignored in IDLE/LOAD.
// - i_pause high in RUN -> PAUSE next cycle; prescaler, counters, positions frozen; o_step=0.
//   i_pause low in PAUSE -> RUN, resuming from frozen prescaler/counter values (no lost ticks).
// - i_stop in RUN/PAUSE -> IDLE; o_step forced 0 that cycle; positions held.
// - i_Reset mid-operation: next cycle all reset values regardless of state or inputs.
// TESTING (TICK_CYCLES=4, N_LANES=4, other defaults)
// 1 Reset for 2 cycles -> o_state=0, o_car_x=0, o_step=0, o_level=0, o_running=0.
// 2 start, level=0, lane0 x=19, lane1 x=0 -> LOAD 1 cycle; lane0 o_step at RUN cycle 40 (x=20),
//   again at cycle 80 (x=0); lane1 (p=9) steps at cycle 36 to x=20, cycle 72 to x=19.
// 3 In RUN at RUN cycle 20 hold i_pause 100 cycles -> o_state=3, no o_step, x unchanged;
//   after release lane0 steps at RUN cycle 40 + 100 + 1(re-entry) counting paused time excluded.
// 4 Eight i_level_up pulses in RUN -> o_level 1..7 then holds 7; lane0 period 2 (step every 8 cycles);
//   level-up with cnt[0]=5 at level 2 (p 6->4) -> lane0 steps on next base_tick.
// 5 i_stop and i_pause same cycle in RUN -> IDLE, o_step=0, x held; i_start in RUN -> ignored.
// 6 i_Reset asserted mid-RUN with i_start high -> next cycle IDLE and all outputs 0; init x=25 -> loads 20.

Source files
------------

// File: rtl/traffic_scheduler_if.sv
// Control/status bundle between the game FSM (master) and the lane scheduler (slave).
// Car positions are packed five bits per lane, lane k at [5k+4:5k].
interface traffic_scheduler_if #(
   parameter int N_LANES = 4
);
   logic                   i_start;
   logic                   i_stop;
   logic                   i_pause;
   logic                   i_level_up;
   logic [2:0]             i_level;
   logic [N_LANES*5-1:0]   i_init_x;
   logic [N_LANES*5-1:0]   o_car_x;
   logic [N_LANES-1:0]     o_step;
   logic [2:0]             o_level;
   logic [1:0]             o_state;
   logic                   o_running;

   modport master (
      output i_start, i_stop, i_pause, i_level_up, i_level, i_init_x,
      input  o_car_x, o_step, o_level, o_state, o_running
   );

   modport slave (
      input  i_start, i_stop, i_pause, i_level_up, i_level, i_init_x,
      output o_car_x, o_step, o_level, o_state, o_running
   );
endinterface

// File: rtl/traffic_scheduler.sv
// Shared-prescaler lane scheduler: steps every lane's car X on a per-lane period
// derived from lane index and difficulty level, with wrap-around at the grid edges.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; positions held
// ST_LOAD  | one cycle: load clamped start X, level; clear prescaler/counters
// ST_RUN   | prescaler runs, lanes step on their schedule
// ST_PAUSE | everything frozen until pause drops
module traffic_scheduler #(
   parameter int N_LANES     = 4,
   parameter int TICK_CYCLES = 1250000,
   parameter int X_MAX       = 20,
   parameter int BASE_PERIOD = 10,
   parameter int MIN_PERIOD  = 2
) (
   input  logic                i_Clk,
   input  logic                i_Reset,
   traffic_scheduler_if.slave  bus
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [4:0]    X_LAST     = 5'(X_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [PW-1:0]              presc_q, presc_d;
   logic [N_LANES-1:0][3:0]    cnt_q, cnt_d;
   logic [N_LANES*5-1:0]       x_q, x_d;
   logic [N_LANES-1:0]         step_q, step_d;
   logic [2:0]                 level_q, level_d;
   logic                       running_q, running_d;
   logic                       base_tick;

   // Evaluated in int so short periods at high level/lane saturate instead of wrapping.
   function automatic logic [3:0] lane_period(input int k, input logic [2:0] lvl);
      int p;
      p = BASE_PERIOD - k - 2 * int'(lvl);
      if (p < MIN_PERIOD) p = MIN_PERIOD;
      if (p > 15) p = 15;
      return 4'(p);
   endfunction

   function automatic logic [4:0] clamp_x(input logic [4:0] x);
      return (x > X_LAST) ? X_LAST : x;
   endfunction

   function automatic logic [4:0] wrap_step(input logic [4:0] x, input logic up);
      logic [4:0] r;
      if (up) r = (x >= X_LAST) ? 5'd0 : x + 5'd1;
      else    r = (x == 5'd0)   ? X_LAST : x - 5'd1;
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      cnt_d     = cnt_q;
      x_d       = x_q;
      step_d    = '0;
      level_d   = level_q;
      base_tick = (presc_q == PRESC_LAST);

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (bus.i_stop) begin
               state_d = ST_IDLE;
            end else begin
               for (int k = 0; k < N_LANES; k++)
                  x_d[5*k +: 5] = clamp_x(bus.i_init_x[5*k +: 5]);
               level_d = bus.i_level;
               presc_d = '0;
               cnt_d   = '0;
               state_d = bus.i_pause ? ST_PAUSE : ST_RUN;
            end
         end
         ST_RUN, ST_PAUSE: begin
            if (bus.i_stop) begin
               state_d = ST_IDLE;
            end else begin
               if (bus.i_level_up && level_q != 3'd7) level_d = level_q + 3'd1;
               if (bus.i_pause) begin
                  state_d = ST_PAUSE;
               end else if (state_q == ST_PAUSE) begin
                  // Re-entry cycle stays frozen so no tick is lost or doubled.
                  state_d = ST_RUN;
               end else begin
                  presc_d = base_tick ? '0 : presc_q + PW'(1);
                  if (base_tick) begin
                     for (int k = 0; k < N_LANES; k++) begin
                        // >= lets a freshly shortened period fire on the next tick.
                        if (cnt_q[k] >= lane_period(k, level_q) - 4'd1) begin
                           cnt_d[k]      = 4'd0;
                           step_d[k]     = 1'b1;
                           x_d[5*k +: 5] = wrap_step(x_q[5*k +: 5], (k % 2) == 0);
                        end else begin
                           cnt_d[k] = cnt_q[k] + 4'd1;
                        end
                     end
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         x_q       <= '0;
         step_q    <= '0;
         level_q   <= 3'd0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         step_q    <= step_d;
         level_q   <= level_d;
         running_q <= running_d;
      end
   end

   assign bus.o_car_x   = x_q;
   assign bus.o_step    = step_q;
   assign bus.o_level   = level_q;
   assign bus.o_state   = state_q;
   assign bus.o_running = running_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed bench for traffic_scheduler with a 4-cycle base tick; expected step
// cycles are counted from the first RUN cycle (RUN cycle 0).
module tb_traffic_scheduler;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;
   int   rc;
   int   a, b, c, d, seen, s0;
   logic [19:0] snap;

   traffic_scheduler_if #(.N_LANES(4)) bus ();

   traffic_scheduler #(
      .N_LANES(4), .TICK_CYCLES(4), .X_MAX(20), .BASE_PERIOD(10), .MIN_PERIOD(2)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
      rc++;
   endtask

   task automatic run_to(input int target);
      while (rc < target) step_clk();
   endtask

   task automatic start_game();
      bus.i_start = 1'b1;
      step_clk();
      chk("load_state", 32'(bus.o_state), 1);
      bus.i_start = 1'b0;
      step_clk();
      rc = 0;
      chk("run_entry", 32'(bus.o_state), 2);
   endtask

   task automatic stop_game();
      bus.i_stop = 1'b1;
      step_clk();
      bus.i_stop = 1'b0;
   endtask

   task automatic wait_step(input int lane, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         step_clk();
         if (bus.o_step[lane]) begin
            at = rc;
            break;
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rc       = 0;
      rst      = 1'b1;
      bus.i_start    = 1'b0;
      bus.i_stop     = 1'b0;
      bus.i_pause    = 1'b0;
      bus.i_level_up = 1'b0;
      bus.i_level    = 3'd0;
      bus.i_init_x   = '0;

      // 1: reset
      step_clk();
      step_clk();
      rst = 1'b0;
      chk("rst_state",   32'(bus.o_state), 0);
      chk("rst_car_x",   32'(bus.o_car_x), 0);
      chk("rst_step",    32'(bus.o_step), 0);
      chk("rst_level",   32'(bus.o_level), 0);
      chk("rst_running", 32'(bus.o_running), 0);

      // 2: basic schedule, lanes p=10,9,8,7 at level 0
      bus.i_init_x = {5'd3, 5'd5, 5'd0, 5'd19};
      start_game();
      chk("run_running", 32'(bus.o_running), 1);
      chk("load_x", 32'(bus.o_car_x), 32'({5'd3, 5'd5, 5'd0, 5'd19}));
      s0 = 0;
      for (int n = 1; n <= 80; n++) begin
         step_clk();
         if (bus.o_step[0]) s0++;
         if (rc == 28) begin
            chk("l3_step28", 32'(bus.o_step), 32'h8);
            chk("l3_x28", 32'(bus.o_car_x[19:15]), 2);
         end
         if (rc == 32) chk("l2_x32", 32'(bus.o_car_x[14:10]), 6);
         if (rc == 36) begin
            chk("l1_step36", 32'(bus.o_step), 32'h2);
            chk("l1_x36", 32'(bus.o_car_x[9:5]), 20);
         end
         if (rc == 40) begin
            chk("l0_step40", 32'(bus.o_step), 32'h1);
            chk("l0_x40", 32'(bus.o_car_x[4:0]), 20);
         end
         if (rc == 41) chk("step_width", 32'(bus.o_step), 0);
         if (rc == 72) chk("l1_x72", 32'(bus.o_car_x[9:5]), 19);
         if (rc == 80) begin
            chk("l0_step80", 32'(bus.o_step), 32'h1);
            chk("l0_wrap80", 32'(bus.o_car_x[4:0]), 0);
         end
      end
      chk("l0_count80", s0, 2);
      stop_game();
      chk("stop_state", 32'(bus.o_state), 0);
      chk("stop_hold_x", 32'(bus.o_car_x), 32'({5'd1, 5'd7, 5'd19, 5'd0}));

      // 3: pause at RUN cycle 20 for 100 cycles
      bus.i_init_x = {5'd3, 5'd5, 5'd0, 5'd19};
      start_game();
      run_to(20);
      snap = bus.o_car_x;
      bus.i_pause = 1'b1;
      seen = 0;
      repeat (100) begin
         step_clk();
         if (bus.o_step != 4'd0) seen++;
         if (rc == 21) begin
            chk("pause_state", 32'(bus.o_state), 3);
            chk("pause_running", 32'(bus.o_running), 0);
         end
      end
      chk("pause_no_step", seen, 0);
      chk("pause_x_frozen", 32'(bus.o_car_x), 32'(snap));
      bus.i_pause = 1'b0;
      wait_step(3, 20, a);
      chk("resume_l3_cycle", a, 129);
      wait_step(0, 20, b);
      chk("resume_l0_cycle", b, 141);
      stop_game();

      // 4: level-ups saturate at 7, then lane 0 period 2
      bus.i_level = 3'd0;
      start_game();
      for (int i = 1; i <= 8; i++) begin
         bus.i_level_up = 1'b1;
         step_clk();
         bus.i_level_up = 1'b0;
         chk("level_up", 32'(bus.o_level), (i > 7) ? 7 : i);
      end
      wait_step(0, 40, a);
      wait_step(0, 40, b);
      chk("l0_period_lvl7", b - a, 8);
      wait_step(3, 40, c);
      wait_step(3, 40, d);
      chk("l3_period_lvl7", d - c, 8);
      stop_game();

      // 4b: level 2 -> 3 with cnt[0]=5 (p 6 -> 4)
      bus.i_level = 3'd2;
      start_game();
      run_to(20);
      bus.i_level_up = 1'b1;
      step_clk();
      bus.i_level_up = 1'b0;
      chk("lvl2_up", 32'(bus.o_level), 3);
      wait_step(0, 20, a);
      chk("lvl2_up_step", a, 24);
      stop_game();

      // 4c: level 1 -> 3 with cnt[0]=5 (p 8 -> 4): counter already past p-1
      bus.i_level = 3'd1;
      start_game();
      run_to(20);
      bus.i_level_up = 1'b1;
      step_clk();
      step_clk();
      bus.i_level_up = 1'b0;
      chk("lvl1_up2", 32'(bus.o_level), 3);
      wait_step(0, 20, a);
      chk("overshoot_step", a, 24);
      stop_game();

      // 5: stop+pause together at a would-be step cycle; start ignored in RUN
      bus.i_level = 3'd0;
      bus.i_init_x = {5'd3, 5'd5, 5'd0, 5'd19};
      start_game();
      run_to(27);
      snap = bus.o_car_x;
      bus.i_stop  = 1'b1;
      bus.i_pause = 1'b1;
      step_clk();
      bus.i_stop  = 1'b0;
      bus.i_pause = 1'b0;
      chk("stop_pause_state", 32'(bus.o_state), 0);
      chk("stop_pause_step", 32'(bus.o_step), 0);
      chk("stop_pause_x", 32'(bus.o_car_x), 32'(snap));
      chk("stop_pause_running", 32'(bus.o_running), 0);
      step_clk();
      step_clk();
      step_clk();
      chk("idle_hold_x", 32'(bus.o_car_x), 32'(snap));
      start_game();
      run_to(5);
      bus.i_init_x = {5'd10, 5'd10, 5'd10, 5'd10};
      bus.i_start = 1'b1;
      step_clk();
      bus.i_start = 1'b0;
      chk("start_in_run_state", 32'(bus.o_state), 2);
      chk("start_in_run_x", 32'(bus.o_car_x), 32'({5'd3, 5'd5, 5'd0, 5'd19}));

      // 6: reset mid-RUN with start high, then clamped load
      bus.i_level = 3'd4;
      rst = 1'b1;
      bus.i_start = 1'b1;
      step_clk();
      rst = 1'b0;
      bus.i_start = 1'b0;
      chk("mid_rst_state", 32'(bus.o_state), 0);
      chk("mid_rst_x", 32'(bus.o_car_x), 0);
      chk("mid_rst_step", 32'(bus.o_step), 0);
      chk("mid_rst_level", 32'(bus.o_level), 0);
      chk("mid_rst_running", 32'(bus.o_running), 0);
      bus.i_init_x = {5'd0, 5'd7, 5'd31, 5'd25};
      start_game();
      chk("clamp_x", 32'(bus.o_car_x), 32'({5'd0, 5'd7, 5'd20, 5'd20}));
      chk("load_level", 32'(bus.o_level), 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
